regfile_sb: RTL and testbench
=============================

# regfile_sb

Parameterised multi-read register file with write-through bypass, a per-entry busy scoreboard and a sequential clear engine. It is the successor to the CPU's fixed 32x32 register file. It sits in the decode stage: operands are read combinationally, results are written back at the clock edge, and long-latency units reserve their destination register so that decode can stall on hazards.

## Interface
Parameters:
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1, entry 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- raddr1  in  ADDR_W  read port 1 address
- raddr2  in  ADDR_W  read port 2 address
- rdata1  out  DATA_W  read port 1 data (combinational)
- rdata2  out  DATA_W  read port 2 data (combinational)
- rbusy1  out  1  entry at raddr1 has a pending writeback
- rbusy2  out  1  entry at raddr2 has a pending writeback
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- rsv_en  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- clr_req  in  1  start a sequential clear of all entries
- clr_busy  out  1  clear engine active
- clr_done  out  1  single-cycle pulse on the cycle after the last entry is cleared

## Operation
- Storage: DEPTH x DATA_W array plus a DEPTH-bit busy vector.
- Effective write: `we_eff = we & ~clr_busy & ~(ZERO_REG & waddr==0)`. On the edge, array[waddr] <= wdata and busy[waddr] <= 0.
- Effective reserve: `rsv_eff = rsv_en & ~clr_busy & ~(ZERO_REG & rsv_addr==0)`. On the edge, busy[rsv_addr] <= 1.
- Reserve and write to the same address in the same cycle: the reserve wins and busy ends at 1, because a new producer was issued. The data is still written.
- Read data:
  - If ZERO_REG and raddr==0, rdata = 0.
  - Else if BYPASS and we_eff and waddr==raddr, rdata = wdata.
  - Else rdata = array[raddr].
- Read busy:
  - rbusy = busy[raddr], with two overrides.
  - It is 0 for entry 0 when ZERO_REG is set.
  - When BYPASS is set, it is forced to 0 if we_eff and waddr==raddr, since the forwarded data is valid that cycle.
  - A same-cycle reserve does not affect rbusy until the next cycle.
- Clear engine, with states IDLE and CLEAR and a counter cnt[ADDR_W-1:0]:
  - IDLE: if clr_req is high, go to CLEAR with cnt=0. Any we/rsv_en in the request cycle are still honoured.
  - CLEAR: each cycle, array[cnt] <= 0, busy[cnt] <= 0 and cnt++.
    - When cnt == DEPTH-1, go to IDLE and assert clr_done for the next cycle.
    - we, rsv_en and clr_req are ignored.
    - Reads return current array contents with no bypass; rbusy reflects the busy vector.
  - clr_busy = (state == CLEAR).
- Reset: all entries 0, busy vector 0, state IDLE, cnt 0, clr_done 0. A reset during CLEAR aborts the clear immediately.

## Timing
- Read latency is 0 cycles (combinational from raddr/we/waddr/wdata).
- A write is visible in the array from the cycle after the edge. With BYPASS it is also visible in the same cycle.
- A reserve is visible on rbusy from the cycle after the edge.
- A clear takes exactly DEPTH cycles in CLEAR. clr_busy is high for DEPTH cycles, starting the cycle after clr_req. clr_done is high for 1 cycle on the first IDLE cycle. Back-to-back clr_req in that cycle starts a new clear.
- Output values during and after reset: rdata = 0, rbusy = 0, clr_busy = 0, clr_done = 0.

## Test plan
- Reset then read: assert rst for 1 cycle, then read every address -> rdata = 0x00000000 and rbusy = 0 on both ports.
- Write/bypass:
  - Write wdata=0xDEADBEEF to addr 5 with raddr1=5 in the same cycle -> rdata1 = 0xDEADBEEF that cycle (BYPASS=1).
  - With BYPASS=0 -> rdata1 = old value that cycle and 0xDEADBEEF the next cycle.
- Zero register: write 0x12345678 to addr 0 and reserve addr 0 -> rdata = 0 and rbusy = 0 on all following cycles.
- Scoreboard:
  - Reserve addr 7 -> rbusy = 1 the next cycle.
  - Write addr 7 with 0xA5A5A5A5 -> rbusy = 0 in the write cycle (bypass) and after.
  - Simultaneous reserve and write of addr 9 -> rbusy = 1 after the edge, and data = written value.
- Clear: fill all 32 entries with nonzero data and reserve addr 3, then pulse clr_req.
  - clr_busy is high for 32 cycles and clr_done pulses once.
  - A write issued during CLEAR is dropped.
  - Afterwards all entries = 0 and no entry is busy.
- Reset mid-clear: assert rst at CLEAR cycle 10 -> next cycle clr_busy = 0, clr_done never pulses, all entries = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-read register file with write-through bypass, per-entry busy scoreboard
// and a sequential clear engine that zeroes one entry per cycle.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt, cnt_nx;
    logic              done_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic              we_eff, rsv_eff;

    assign clr_busy = (state == CLEAR);
    assign we_eff   = we & ~clr_busy & ~(ZR & (waddr == '0));
    assign rsv_eff  = rsv_en & ~clr_busy & ~(ZR & (rsv_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            clr_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = '0;
                end
            end
            CLEAR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A reserve is applied after the write so a same-cycle reserve leaves the entry busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy_q <= '0;
        end else if (state == CLEAR) begin
            mem[cnt]    <= '0;
            busy_q[cnt] <= 1'b0;
        end else begin
            if (we_eff) begin
                mem[waddr]    <= wdata;
                busy_q[waddr] <= 1'b0;
            end
            if (rsv_eff) busy_q[rsv_addr] <= 1'b1;
        end
    end

    always_comb begin
        rdata1 = mem[raddr1];
        rbusy1 = busy_q[raddr1];
        if (BP && we_eff && (waddr == raddr1)) begin
            rdata1 = wdata;
            rbusy1 = 1'b0;
        end
        if (ZR && (raddr1 == '0)) begin
            rdata1 = '0;
            rbusy1 = 1'b0;
        end
    end

    always_comb begin
        rdata2 = mem[raddr2];
        rbusy2 = busy_q[raddr2];
        if (BP && we_eff && (waddr == raddr2)) begin
            rdata2 = wdata;
            rbusy2 = 1'b0;
        end
        if (ZR && (raddr2 == '0)) begin
            rdata2 = '0;
            rbusy2 = 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing and a non-bypassing instance share
// stimulus; expected values go through a queue and are popped at each sample.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raddr1, raddr2, waddr, rsv_addr;
    logic [31:0] wdata;
    logic        we, rsv_en, clr_req;
    logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic        rbusy1, rbusy2, nb_rbusy1, nb_rbusy2;
    logic        clr_busy, clr_done, nb_clr_busy, nb_clr_done;

    logic [31:0] exp_q[$];
    logic [31:0] mem_m [32];
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt, done_cnt, done_at;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .rbusy1(rbusy1), .rbusy2(rbusy2),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(nb_rdata1), .rdata2(nb_rdata2), .rbusy1(nb_rbusy1), .rbusy2(nb_rbusy2),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr_req(clr_req), .clr_busy(nb_clr_busy), .clr_done(nb_clr_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    endtask

    task automatic check_all(input string tag, input int busy_addr);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            exp_q.push_back(mem_m[i]);
            exp_q.push_back(mem_m[31 - i]);
            exp_q.push_back({31'b0, i == busy_addr});
            exp_q.push_back({31'b0, (31 - i) == busy_addr});
            #1;
            chk({tag, "_rdata1"}, rdata1);
            chk({tag, "_rdata2"}, rdata2);
            chk({tag, "_rbusy1"}, {31'b0, rbusy1});
            chk({tag, "_rbusy2"}, {31'b0, rbusy2});
        end
    endtask

    initial begin
        rst = 1'b1; raddr1 = '0; raddr2 = '0;
        idle_inputs();
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        step();
        exp_q.push_back(32'd0);
        chk("reset_clr_busy", {31'b0, clr_busy});
        rst = 1'b0;
        check_all("reset", -1);

        // write 5 with same-cycle read: bypass vs no bypass
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        #1;
        chk("bypass_rdata1", rdata1);
        chk("nobypass_old_rdata1", nb_rdata1);
        step();
        idle_inputs();
        exp_q.push_back(32'hDEADBEEF);
        #1;
        chk("nobypass_next_rdata1", nb_rdata1);

        // zero register ignores write and reserve
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        chk("zero_same_rdata1", rdata1);
        chk("zero_same_rbusy1", {31'b0, rbusy1});
        step();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            chk("zero_rdata2", rdata2);
            chk("zero_rbusy2", {31'b0, rbusy2});
            chk("zero_nb_rdata1", nb_rdata1);
            step();
        end

        // reserve 7, visible only after the edge
        rsv_en = 1'b1; rsv_addr = 5'd7; raddr1 = 5'd7;
        exp_q.push_back(32'h0);
        #1;
        chk("rsv_same_rbusy1", {31'b0, rbusy1});
        step();
        idle_inputs();
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        #1;
        chk("rsv_next_rbusy1", {31'b0, rbusy1});
        chk("rsv_next_nb_rbusy1", {31'b0, nb_rbusy1});

        // write 7 clears busy; bypass forwards the clear that cycle
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        chk("wr7_same_rbusy1", {31'b0, rbusy1});
        chk("wr7_same_nb_rbusy1", {31'b0, nb_rbusy1});
        chk("wr7_same_rdata1", rdata1);
        step();
        idle_inputs();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hA5A5A5A5);
        #1;
        chk("wr7_next_rbusy1", {31'b0, rbusy1});
        chk("wr7_next_nb_rdata1", nb_rdata1);

        // simultaneous reserve and write of 9: reserve wins, data still lands
        we = 1'b1; waddr = 5'd9; wdata = 32'h0BADF00D;
        rsv_en = 1'b1; rsv_addr = 5'd9; raddr2 = 5'd9;
        step();
        idle_inputs();
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0BADF00D);
        #1;
        chk("rw9_rbusy2", {31'b0, rbusy2});
        chk("rw9_rdata2", rdata2);

        // fill all entries with nonzero data, then reserve 3
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = $urandom() | 32'h1;
            mem_m[i] = (i == 0) ? 32'h0 : wdata;
            step();
        end
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        step();
        idle_inputs();
        check_all("fill", 3);

        // clear; a write and reserve mid-clear are dropped
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 5) begin
                we = 1'b1; waddr = 5'd2; wdata = 32'hFFFFFFFF;
                rsv_en = 1'b1; rsv_addr = 5'd4;
                raddr1 = 5'd2; raddr2 = 5'd20;
                exp_q.push_back(32'h0);
                exp_q.push_back(mem_m[20]);
            end
            #1;
            if (cyc == 5) begin
                chk("clr_nobypass_rdata1", rdata1);
                chk("clr_uncleared_rdata2", rdata2);
            end
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_at = cyc;
            end
            step();
            idle_inputs();
        end
        exp_q.push_back(32'd32);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd32);
        chk("clr_busy_cycles", 32'(busy_cnt));
        chk("clr_done_pulses", 32'(done_cnt));
        chk("clr_done_cycle", 32'(done_at));
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        check_all("after_clear", -1);

        // reset at clear cycle 10 aborts the clear
        for (int i = 15; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'hC0DE0000 | 32'(i);
            step();
        end
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        chk("rst_mid_clr_busy", {31'b0, clr_busy});
        busy_cnt = 0; done_cnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            step();
        end
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        chk("rst_mid_clr_done_pulses", 32'(done_cnt));
        chk("rst_mid_busy_cycles", 32'(busy_cnt));
        check_all("after_rst_mid", -1);

        exp_q.push_back(32'd0);
        chk("queue_drained", 32'(exp_q.size() - 1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
